// File: rtl/captura_pkg.sv
// Shared definitions for the user-input capture path: FSM state encoding and data width
// used by captura_entrada and the downstream encoder/display stages.
package captura_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } captura_state_t;

    // Counter width able to hold DEBOUNCE_CYCLES-1, never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sincronizador.sv
// Generic 2-flop synchroniser for asynchronous inputs; the first flop may go metastable,
// the second presents a settled value to the clock domain.
module sincronizador #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_p0;
    logic [WIDTH-1:0] sync_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/captura_entrada.sv
// Switch/button capture front-end: debounces the confirm button and latches the switches
// once per press. Define SYNC_2FF_EN to pass Button/Switches through a 2-flop synchroniser.
module captura_entrada
    import captura_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Switches,
    input  logic              Button,
    input  logic              Clear,
    output logic [DATA_W-1:0] Input,
    output logic              Ready,
    output logic              Busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic              button_s;
    logic [DATA_W-1:0] switches_s;

`ifdef SYNC_2FF_EN
    logic [DATA_W:0] sync_q;

    sincronizador #(
        .WIDTH (DATA_W + 1)
    ) u_sincronizador (
        .clk (Clock),
        .rst (Reset),
        .d   ({Button, Switches}),
        .q   (sync_q)
    );

    assign button_s   = sync_q[DATA_W];
    assign switches_s = sync_q[DATA_W-1:0];
`else
    assign button_s   = Button;
    assign switches_s = Switches;
`endif

    captura_state_t   state;
    logic [CNT_W-1:0] cnt;

    // Busy is registered together with the state so it mirrors the debounce states exactly.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            Input <= '0;
            Ready <= 1'b0;
            Busy  <= 1'b0;
        end else begin
            // A capture later in this block overrides the clear.
            if (Clear) begin
                Ready <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (button_s) begin
                        state <= PRESS_DB;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                    end
                end

                PRESS_DB: begin
                    if (!button_s) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        Input <= switches_s;
                        Ready <= 1'b1;
                        state <= HELD;
                        Busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                HELD: begin
                    if (!button_s) begin
                        state <= RELEASE_DB;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                    end
                end

                RELEASE_DB: begin
                    if (button_s) begin
                        state <= HELD;
                        Busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/captura_entrada.md
# captura_entrada

Front-end capture stage for the board's switch/push-button user input. It synchronises four data switches and a confirm button, then debounces the button with a counter-based state machine. On a confirmed press it latches the switch value and raises a sticky `Ready` flag. Its `Input`/`Ready` outputs drive the downstream encoder stage directly, and that stage's output feeds the 7-segment display decoder.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: number of consecutive stable cycles required to accept a button press or release. Must be ≥ 1.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)` (minimum 1): debounce counter width. Derived; not overridden.

Ports (name, direction, width, meaning):
- `Clock`, in, 1: single system clock, rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `Switches`, in, 4: raw data switches, asynchronous to `Clock`.
- `Button`, in, 1: raw confirm button, active-high when pressed, asynchronous and bouncy.
- `Clear`, in, 1: synchronous, single-cycle request to drop `Ready`.
- `Input`, out, 4: registered captured switch value.
- `Ready`, out, 1: sticky flag, high while `Input` holds a valid capture.
- `Busy`, out, 1: high while a debounce window is counting.

## Operation
- `Button_s` and `Switches_s` denote the conditioned inputs: synchronised or direct, see Configuration.
- FSM states:
  - `IDLE`: `Button_s`=1 → `PRESS_DB`, cnt←0.
  - `PRESS_DB`:
    - `Button_s`=0 → `IDLE`. This is a bounce; nothing is captured.
    - Otherwise, if cnt==`DEBOUNCE_CYCLES`-1: capture (`Input`←`Switches_s`, `Ready`←1) and go to `HELD`.
    - Otherwise cnt←cnt+1.
  - `HELD`: `Button_s`=0 → `RELEASE_DB`, cnt←0.
  - `RELEASE_DB`:
    - `Button_s`=1 → `HELD`.
    - Otherwise, if cnt==`DEBOUNCE_CYCLES`-1 → `IDLE`.
    - Otherwise cnt←cnt+1.
- Exactly one capture per press. Holding the button never recaptures, and a press cannot be recognised again until the release has been debounced.
- `Ready` stays high until `Clear` or `Reset`.
- A new capture while `Ready`=1 overwrites `Input`; `Ready` stays 1.
- `Clear` and a capture in the same cycle: the capture wins, so `Ready`=1 with the new value.
- `Clear` with `Ready`=0 has no effect.
- `Clear` does not change `Input`. `Input` is only meaningful while `Ready`=1.
- `Busy` = (state==`PRESS_DB`) | (state==`RELEASE_DB`), decoded from registered state.
- The counter never wraps. It is reset to 0 on every entry to a debounce state.

## Timing
- Reset values (asynchronous): state=`IDLE`, cnt=0, `Input`=4'b0000, `Ready`=0, `Busy`=0, synchroniser flops=0.
- `Reset` asserted mid-debounce or in `HELD` aborts immediately, with no capture. After release, a button already held low-to-high is treated as a fresh press.
- Latency, with `Button` first sampled high at edge k and held stable:
  - With `SYNC_2FF_EN`: `Ready` rises after edge k+2+`DEBOUNCE_CYCLES`.
  - Without `SYNC_2FF_EN`: `Ready` rises after edge k+`DEBOUNCE_CYCLES`.
- The captured value is the `Switches` value sampled at the raw input at edge k+`DEBOUNCE_CYCLES` in both builds.
- `Clear` takes effect at the next edge: `Ready`=0 in the following cycle.
- All outputs are registered or decoded from registered state only. There is no combinational input-to-output path.

## Configuration
- `SYNC_2FF_EN`:
  - Defined: `Button` and `Switches` each pass through a 2-flop synchroniser before use, adding 2 cycles of latency.
  - Undefined: the raw inputs are used directly, for simulation or for inputs that are already synchronous.
  - The FSM behaviour is identical in both builds.

## Structure
- Shared package `captura_pkg`:
  - FSM state enum `captura_state_t` (`IDLE`, `PRESS_DB`, `HELD`, `RELEASE_DB`), 2 bits.
  - `DATA_W`=4 constant, shared with the encoder and display stages.
- Sub-module `sincronizador`: a generic 2-flop synchroniser with width parameter, asynchronous active-high reset, instantiated once for the 5 bits {`Button`, `Switches`}. It is only instantiated under `SYNC_2FF_EN`.

## Test plan
Bench settings: `DEBOUNCE_CYCLES`=4; each scenario is run both with and without `SYNC_2FF_EN`.

1. Clean press: `Switches`=4'hA, `Button` held high for 10 cycles → `Ready` rises at the latency above, `Input`=4'hA, `Busy` is high for exactly 4 cycles, then one capture only.
2. Bounce: `Button` pattern 1,1,0,1,1,0 followed by low → no capture, `Ready`=0, state returns to `IDLE`.
3. Overwrite and clear:
   - Capture 4'h3, release, then capture 4'hC → `Input`=4'hC and `Ready` stays 1.
   - Pulse `Clear` → `Ready`=0 next cycle; `Input` remains 4'hC.
4. `Clear` asserted on the capture edge of 4'h5 → `Ready`=1, `Input`=4'h5.
5. `Reset` pulsed in `PRESS_DB` (cnt=2) and again in `HELD` → all outputs go to 0 asynchronously, no capture occurs, and a new full press after reset captures correctly.
6. Release bounce: after a capture, `Button` pattern 0,0,1,0,0,0,0 → the FSM returns to `HELD` once, then reaches `IDLE`, with no second capture.
